// File: rtl/branch_predict_eval.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_eval
// Brief    : EX-stage branch resolver with bimodal 2-bit predictor table,
//            registered mispredict/redirect and saturating statistics.
// Revision : 1.0
// ============================================================================
module branch_predict_eval #(
    parameter int WordSize   = 32,
    parameter int Entries    = 64,
    parameter int IdxLsb     = 2,
    parameter int CountWidth = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [WordSize-1:0]   pred_pc,
    output logic                  pred_taken,
    input  logic                  res_valid,
    input  logic [WordSize-1:0]   res_pc,
    input  logic                  res_pred_taken,
    input  logic [1:0]            branch_cond,
    input  logic [WordSize-1:0]   alu_out,
    input  logic [WordSize-1:0]   target,
    input  logic                  flush,
    output logic                  act_taken,
    output logic                  mispredict,
    output logic [WordSize-1:0]   redirect_pc,
    output logic [CountWidth-1:0] branch_count,
    output logic [CountWidth-1:0] mispred_count
);
    localparam int         IdxW     = (Entries > 1) ? $clog2(Entries) : 1;
    localparam logic [1:0] CondNe   = 2'd0;
    localparam logic [1:0] CondAlu  = 2'd1;
    localparam logic [1:0] CondNalu = 2'd2;

    logic [1:0]            tbl_q [Entries];
    logic [IdxW-1:0]       pred_idx;
    logic [IdxW-1:0]       res_idx;
    logic                  dir_d;
    logic                  res_go;
    logic                  train;
    logic                  mis_d;
    logic [1:0]            ctr_cur;
    logic [1:0]            ctr_d;
    logic [WordSize-1:0]   redir_d;
    logic                  act_q;
    logic                  mis_q;
    logic [WordSize-1:0]   redir_q;
    logic [CountWidth-1:0] bc_q;
    logic [CountWidth-1:0] mc_q;

    assign pred_idx   = pred_pc[IdxLsb +: IdxW];
    assign res_idx    = res_pc[IdxLsb +: IdxW];
    // Table read is the registered state, so a same-cycle write is not seen.
    assign pred_taken = tbl_q[pred_idx][1];

    always_comb begin
        dir_d = 1'b1;
        case (branch_cond)
            CondNe:   dir_d = 1'b0;
            CondAlu:  dir_d = |alu_out;
            CondNalu: dir_d = ~|alu_out;
            default:  dir_d = 1'b1;
        endcase
    end

    assign res_go  = res_valid & ~flush;
    assign train   = res_go & ((branch_cond == CondAlu) | (branch_cond == CondNalu));
    assign mis_d   = res_go & (dir_d != res_pred_taken);
    assign redir_d = dir_d ? target : (res_pc + WordSize'(4));
    assign ctr_cur = tbl_q[res_idx];

    always_comb begin
        ctr_d = ctr_cur;
        if (dir_d && ctr_cur != 2'b11) begin
            ctr_d = ctr_cur + 2'b01;
        end else if (!dir_d && ctr_cur != 2'b00) begin
            ctr_d = ctr_cur - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < Entries; i++) begin
                tbl_q[i] <= 2'b01;
            end
        end else if (train) begin
            tbl_q[res_idx] <= ctr_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_q   <= 1'b0;
            mis_q   <= 1'b0;
            redir_q <= '0;
            bc_q    <= '0;
            mc_q    <= '0;
        end else begin
            mis_q <= mis_d;
            if (res_go) begin
                act_q   <= dir_d;
                redir_q <= redir_d;
            end
            if (train && bc_q != {CountWidth{1'b1}}) begin
                bc_q <= bc_q + CountWidth'(1);
            end
            if (mis_d && mc_q != {CountWidth{1'b1}}) begin
                mc_q <= mc_q + CountWidth'(1);
            end
        end
    end

    assign act_taken     = act_q;
    assign mispredict    = mis_q;
    assign redirect_pc   = redir_q;
    assign branch_count  = bc_q;
    assign mispred_count = mc_q;
endmodule
`default_nettype wire

// File: tb/tb_branch_predict_eval.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_eval
// Brief    : Vector table, directed corner sequences and random stimulus
//            against an abstract predictor model; second DUT has 2-bit counters.
// Revision : 1.0
// ============================================================================
module tb_branch_predict_eval;
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pred_pc, res_pc, alu_out, target;
    logic        res_valid, res_pred_taken, flush;
    logic [1:0]  branch_cond;
    logic        pred_taken, act_taken, mispredict;
    logic [31:0] redirect_pc;
    logic [15:0] branch_count, mispred_count;
    logic        p2, a2, m2;
    logic [31:0] r2;
    logic [1:0]  bc2, mc2;

    always #5 clk = ~clk;

    branch_predict_eval dut (
        .clk(clk), .rstn(rstn), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_pc(res_pc), .res_pred_taken(res_pred_taken),
        .branch_cond(branch_cond), .alu_out(alu_out), .target(target), .flush(flush),
        .act_taken(act_taken), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispred_count(mispred_count)
    );

    branch_predict_eval #(.CountWidth(2)) dut2 (
        .clk(clk), .rstn(rstn), .pred_pc(pred_pc), .pred_taken(p2),
        .res_valid(res_valid), .res_pc(res_pc), .res_pred_taken(res_pred_taken),
        .branch_cond(branch_cond), .alu_out(alu_out), .target(target), .flush(flush),
        .act_taken(a2), .mispredict(m2), .redirect_pc(r2),
        .branch_count(bc2), .mispred_count(mc2)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Abstract model: integer counters per index, plain saturation arithmetic.
    int          mt [64];
    logic        m_act, m_mis;
    logic [31:0] m_red;
    int          mbc, mmc;

    function automatic int idx(input logic [31:0] pc);
        return (pc / 4) % 64;
    endfunction

    function automatic logic direction(input logic [1:0] c, input logic [31:0] a);
        if (c == 2'd0) return 1'b0;
        if (c == 2'd1) return (a != 0);
        if (c == 2'd2) return (a == 0);
        return 1'b1;
    endfunction

    function automatic int min3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mt[i] = 1;
        m_act = 0; m_mis = 0; m_red = 0; mbc = 0; mmc = 0;
    endtask

    task automatic model_edge();
        logic d;
        m_mis = 0;
        if (res_valid && !flush) begin
            d     = direction(branch_cond, alu_out);
            m_act = d;
            m_mis = (d != res_pred_taken);
            m_red = d ? target : res_pc + 32'd4;
            if (m_mis && mmc < 65535) mmc++;
            if (branch_cond == 2'd1 || branch_cond == 2'd2) begin
                if (mbc < 65535) mbc++;
                if (d) mt[idx(res_pc)] = (mt[idx(res_pc)] == 3) ? 3 : mt[idx(res_pc)] + 1;
                else   mt[idx(res_pc)] = (mt[idx(res_pc)] == 0) ? 0 : mt[idx(res_pc)] - 1;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] a,
                         input logic [31:0] pc, input logic p, input logic [31:0] t,
                         input logic f, input logic [31:0] ppc);
        res_valid = v; branch_cond = c; alu_out = a; res_pc = pc;
        res_pred_taken = p; target = t; flush = f; pred_pc = ppc;
    endtask

    // Entered at posedge+1 with inputs driven; leaves at the next posedge+1.
    task automatic cycle();
        #1;
        chk("pred_taken", pred_taken, mt[idx(pred_pc)] >= 2);
        chk("pred_taken_w2", p2, mt[idx(pred_pc)] >= 2);
        @(posedge clk);
        model_edge();
        #1;
        chk("act_taken", act_taken, m_act);
        chk("mispredict", mispredict, m_mis);
        if (m_mis) chk("redirect_pc", redirect_pc, m_red);
        chk("branch_count", branch_count, mbc);
        chk("mispred_count", mispred_count, mmc);
        chk("branch_count_w2", bc2, min3(mbc));
        chk("mispred_count_w2", mc2, min3(mmc));
    endtask

    task automatic idle(input logic [31:0] ppc);
        drive(0, 2'd0, 0, 0, 0, 0, 0, ppc);
    endtask

    typedef struct {
        logic [1:0]  cond;
        logic [31:0] alu;
        logic [31:0] pc;
        logic        pred;
        logic [31:0] tgt;
        logic        e_act;
        logic        e_mis;
        logic [31:0] e_red;
    } vec_t;

    vec_t vecs [6];
    int   saved_bc, saved_mc;
    logic saved_act;

    initial begin
        vecs[0] = '{2'd1, 32'd0, 32'h10,       1'b0, 32'h80,   1'b0, 1'b0, 32'h14};
        vecs[1] = '{2'd2, 32'd5, 32'h20,       1'b1, 32'h90,   1'b0, 1'b1, 32'h24};
        vecs[2] = '{2'd0, 32'd7, 32'hFFFFFFFC, 1'b1, 32'h500,  1'b0, 1'b1, 32'h0};
        vecs[3] = '{2'd3, 32'd0, 32'h30,       1'b0, 32'h1234, 1'b1, 1'b1, 32'h1234};
        vecs[4] = '{2'd3, 32'd0, 32'h34,       1'b1, 32'h2000, 1'b1, 1'b0, 32'h2000};
        vecs[5] = '{2'd2, 32'd0, 32'h38,       1'b1, 32'h700,  1'b1, 1'b0, 32'h700};

        rstn = 1'b0;
        idle(32'h0);
        model_reset();
        #12;
        chk("rst_pred_pc0", pred_taken, 0);
        pred_pc = 32'hFC;
        #1;
        chk("rst_pred_pcFC", pred_taken, 0);
        chk("rst_mispredict", mispredict, 0);
        chk("rst_act", act_taken, 0);
        chk("rst_redirect", redirect_pc, 0);
        chk("rst_bc", branch_count, 0);
        chk("rst_mc", mispred_count, 0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        // ALU taken, predicted not-taken
        drive(1, 2'd1, 32'd1, 32'h100, 0, 32'h200, 0, 32'h0);
        cycle();
        chk("alu_act", act_taken, 1);
        chk("alu_mis", mispredict, 1);
        chk("alu_redirect", redirect_pc, 32'h200);
        chk("alu_mc", mispred_count, 1);
        idle(32'h100);
        #1 chk("alu_trained", pred_taken, 1);
        cycle();
        chk("pulse_one_cycle", mispredict, 0);

        // NALU saturation up and down at 0x40
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'd2, 32'd0, 32'h40, mt[16] >= 2, 32'h600, 0, 32'h40);
            cycle();
        end
        chk("nalu_bc4", branch_count, 5);
        chk("nalu_sat3", mt[16], 3);
        chk("nalu_pred_hi", pred_taken, 1);
        for (int i = 0; i < 5; i++) begin
            drive(1, 2'd2, 32'd1, 32'h40, mt[16] >= 2, 32'h600, 0, 32'h40);
            cycle();
        end
        drive(1, 2'd2, 32'd0, 32'h40, 0, 32'h600, 0, 32'h40);
        cycle();
        #1 chk("nalu_floor", pred_taken, 0);

        // AL predicted taken: no mispredict, no training
        saved_bc = branch_count;
        drive(1, 2'd3, 32'd0, 32'h70, 1, 32'h400, 0, 32'h70);
        cycle();
        chk("al_nomis", mispredict, 0);
        chk("al_bc_same", branch_count, saved_bc);
        idle(32'h70);
        #1 chk("al_no_train", pred_taken, 0);
        cycle();

        foreach (vecs[k]) begin
            drive(1, vecs[k].cond, vecs[k].alu, vecs[k].pc, vecs[k].pred, vecs[k].tgt, 0, 32'h0);
            cycle();
            chk($sformatf("vec%0d_act", k), act_taken, vecs[k].e_act);
            chk($sformatf("vec%0d_mis", k), mispredict, vecs[k].e_mis);
            if (vecs[k].e_mis) chk($sformatf("vec%0d_redir", k), redirect_pc, vecs[k].e_red);
        end
        chk("w2_mc_sat", mc2, 3);

        // Flushed mispredicting resolve is squashed
        saved_bc = branch_count; saved_mc = mispred_count; saved_act = act_taken;
        drive(1, 2'd1, 32'd1, 32'h70, 0, 32'h900, 1, 32'h70);
        cycle();
        chk("flush_nomis", mispredict, 0);
        chk("flush_bc", branch_count, saved_bc);
        chk("flush_mc", mispred_count, saved_mc);
        chk("flush_act", act_taken, saved_act);
        idle(32'h70);
        #1 chk("flush_no_train", pred_taken, 0);
        cycle();

        // Reset while a mispredict pulse is showing
        drive(1, 2'd1, 32'd1, 32'h60, 0, 32'hA00, 0, 32'h60);
        cycle();
        chk("pre_rst_mis", mispredict, 1);
        #2 rstn = 1'b0;
        idle(32'h60);
        model_reset();
        #1;
        chk("midrst_mis", mispredict, 0);
        chk("midrst_table", pred_taken, 0);
        chk("midrst_mc", mispred_count, 0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_mis", mispredict, 0);

        // Same-cycle read and write of index 2
        drive(1, 2'd1, 32'd3, 32'h8, 0, 32'hB00, 0, 32'h8);
        #1 chk("rbw_old", pred_taken, 0);
        cycle();
        chk("rbw_new", pred_taken, 1);
        idle(32'h8);
        cycle();

        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) != 0) ? 32'd0 : $urandom(),
                  32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3) * 256),
                  1'($urandom_range(0, 1)), $urandom(),
                  $urandom_range(0, 19) == 0,
                  32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3) * 256));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
`default_nettype wire
